// File: rtl/divider16by8_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
interface divider16by8_if #(parameter int WIDTH = 8);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 overflow;
  logic                 divbyzero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, overflow, divbyzero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, overflow, divbyzero
  );
endinterface

// File: rtl/divider16by8.sv
// Signed 2W/W restoring divider, one quotient bit per clock,
// truncating toward zero with quotient saturation.
module divider16by8 #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    divider16by8_if.slave bus
);

    localparam int N  = 2 * WIDTH;
    localparam int CW = $clog2(N);
    localparam logic [N-1:0] PMAX = N'((1 << (WIDTH - 1)) - 1);
    localparam logic [N-1:0] NMAX = N'(1 << (WIDTH - 1));

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   dvd;
    logic [WIDTH:0] rem;
    logic [WIDTH-1:0] dabs;
    logic           sa, sb, dz;

    logic [WIDTH:0]   shl;
    logic             ge;
    logic             neg;
    logic [WIDTH-1:0] qfix, rfix;
    logic             ovfix;

    assign shl = {rem[WIDTH-1:0], dvd[N-1]};
    assign ge  = (shl >= {1'b0, dabs});
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = CALC;
            CALC:    if (cnt == CW'(N - 1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // dvd holds the quotient magnitude once all N bits are shifted in
    always_comb begin
        qfix  = '0;
        ovfix = 1'b0;
        rfix  = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        neg   = (sa ^ sb) && (dvd != '0);
        if (dz) begin
            rfix = '0;
        end else if (neg) begin
            if (dvd > NMAX) begin
                qfix  = {1'b1, {(WIDTH-1){1'b0}}};
                ovfix = 1'b1;
            end else begin
                qfix = -dvd[WIDTH-1:0];
            end
        end else if (dvd > PMAX) begin
            qfix  = {1'b0, {(WIDTH-1){1'b1}}};
            ovfix = 1'b1;
        end else begin
            qfix = dvd[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            dvd           <= '0;
            rem           <= '0;
            dabs          <= '0;
            sa            <= 1'b0;
            sb            <= 1'b0;
            dz            <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.overflow  <= 1'b0;
            bus.divbyzero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa   <= bus.dividend[N-1];
                        sb   <= bus.divisor[WIDTH-1];
                        dz   <= (bus.divisor == '0);
                        dvd  <= bus.dividend[N-1] ?
                                -bus.dividend : bus.dividend;
                        dabs <= bus.divisor[WIDTH-1] ?
                                -bus.divisor : bus.divisor;
                        rem  <= '0;
                        cnt  <= '0;
                    end
                end
                CALC: begin
                    rem <= ge ? (shl - {1'b0, dabs}) : shl;
                    dvd <= {dvd[N-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    bus.quotient  <= qfix;
                    bus.remainder <= rfix;
                    bus.overflow  <= ovfix;
                    bus.divbyzero <= dz;
                    bus.done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider16by8.sv
// Directed bench for divider16by8: latency, signs, saturation,
// zero divisor, handshake corner cases and mid-operation reset.
module tb_divider16by8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   lat, bc, dn;

    divider16by8_if #(.WIDTH(8)) bus ();

    divider16by8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge right after E0
    task automatic go(input logic [15:0] a, input logic [7:0] b);
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(output int l, output int b);
        l = 0;
        b = 0;
        while (!bus.done && l < 40) begin
            if (bus.busy) b++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic res(input string tag, input logic [7:0] q,
                       input logic [7:0] r, input logic ov,
                       input logic dz);
        check({tag, " done"}, {31'b0, bus.done}, 32'd1);
        check({tag, " busy@done"}, {31'b0, bus.busy}, 32'd0);
        check({tag, " quotient"}, {24'b0, bus.quotient}, {24'b0, q});
        check({tag, " remainder"}, {24'b0, bus.remainder}, {24'b0, r});
        check({tag, " overflow"}, {31'b0, bus.overflow}, {31'b0, ov});
        check({tag, " divbyzero"}, {31'b0, bus.divbyzero}, {31'b0, dz});
    endtask

    task automatic op(input string tag, input logic [15:0] a,
                      input logic [7:0] b, input logic [7:0] q,
                      input logic [7:0] r, input logic ov,
                      input logic dz);
        go(a, b);
        wait_done(lat, bc);
        check({tag, " latency"}, lat, 32'd17);
        check({tag, " busy cycles"}, bc, 32'd17);
        res(tag, q, r, ov, dz);
        @(negedge clk);
        check({tag, " done pulse"}, {31'b0, bus.done}, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, " busy"}, {31'b0, bus.busy}, 32'd0);
        check({tag, " done"}, {31'b0, bus.done}, 32'd0);
        check({tag, " quotient"}, {24'b0, bus.quotient}, 32'd0);
        check({tag, " remainder"}, {24'b0, bus.remainder}, 32'd0);
        check({tag, " overflow"}, {31'b0, bus.overflow}, 32'd0);
        check({tag, " divbyzero"}, {31'b0, bus.divbyzero}, 32'd0);
    endtask

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        op("100/7",   16'd100,   8'd7,   8'h0E, 8'h02, 1'b0, 1'b0);
        op("-100/7",  -16'sd100, 8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0);
        op("100/-7",  16'd100,   -8'sd7, 8'hF2, 8'h02, 1'b0, 1'b0);
        op("-100/-7", -16'sd100, -8'sd7, 8'h0E, 8'hFE, 1'b0, 1'b0);
        op("1000/7",  16'd1000,  8'd7,   8'h7F, 8'h06, 1'b1, 1'b0);
        op("-1024/8", -16'sd1024, 8'd8,  8'h80, 8'h00, 1'b0, 1'b0);
        op("-32768/-1", 16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b1, 1'b0);
        op("-32768/-128", 16'h8000, 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0);
        op("55/0",    16'd55,    8'd0,   8'h00, 8'h00, 1'b0, 1'b1);
        op("10/3",    16'd10,    8'd3,   8'h03, 8'h01, 1'b0, 1'b0);

        // second request at iteration 5 must be dropped
        go(16'd100, 8'd7);
        repeat (5) @(negedge clk);
        go(16'd1000, 8'd3);
        wait_done(lat, bc);
        check("ignored latency", lat, 32'd11);
        res("ignored", 8'h0E, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        check("ignored no requeue", {31'b0, bus.busy}, 32'd0);

        // start held through the op is taken in the done cycle
        go(-16'sd100, 8'd7);
        bus.dividend = 16'd100;
        bus.divisor  = -8'sd7;
        bus.start    = 1'b1;
        wait_done(lat, bc);
        check("held first latency", lat, 32'd17);
        res("held first", 8'hF2, 8'hFE, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        check("held second busy", {31'b0, bus.busy}, 32'd1);
        wait_done(lat, bc);
        check("held second latency", lat, 32'd17);
        res("held second", 8'hF2, 8'h02, 1'b0, 1'b0);
        @(negedge clk);

        // reset in the middle of an operation
        go(16'd100, 8'd7);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("midreset no done", dn, 32'd0);
        op("50/5", 16'd50, 8'd5, 8'h0A, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
